reaction_game_ctrl: RTL and testbench
=====================================

Name: reaction_game_ctrl

Overview:
Parametrised round controller for the button-reaction game. It picks a random lane, lights it, and times the player's response. It scores hits and misses over a fixed number of rounds, then reports done. It sits between the debounced/synchronised button inputs and the score display/decoder logic, and generalises lane count, round count, timeout window and score width.

Parameters:
N_LANES, 4, number of button/light lanes (2..16)
ROUNDS, 10, rounds per game (1..255)
TIMEOUT, 50_000_000, reaction window in clk cycles
SCORE_W, 8, width of score and miss counters
LFSR_SEED, 16'hACE1, nonzero reset seed of internal 16-bit LFSR
TIMEOUT_STEP, 2_000_000, window reduction per hit (SPEEDUP_EN only)
TIMEOUT_MIN, 10_000_000, window floor (SPEEDUP_EN only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; begins a game when sampled high in IDLE or FINISH
btn  in  N_LANES  synchronised, debounced buttons, active-high
lights  out  N_LANES  one-hot lit lane, all-zero when none lit
score  out  SCORE_W  hits this game
misses  out  SCORE_W  misses this game
round_cnt  out  8  rounds completed this game
busy  out  1  high in every state except IDLE and FINISH
done  out  1  high in FINISH

Behaviour:
- Reset is asynchronous and active-high, on clk and rst. Reset values: state=IDLE; lights, score, misses, round_cnt, busy and done = 0; LFSR=LFSR_SEED; btn_prev=0; timer=0.
- The LFSR is a 16-bit Galois LFSR with taps 16,14,13,11. It free-runs every cycle, including IDLE, so lane choice depends on when the player presses start.
- Lane select: lane = lfsr[LW-1:0], where LW=clog2(N_LANES). If lane >= N_LANES, subtract N_LANES once. The resulting bias is accepted.
- Button edge: press = btn & ~btn_prev. btn_prev is registered every cycle.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: one cycle. Zero score, misses and round_cnt. -> ARM.
  - ARM: one cycle. Latch lane. Load the timer with the current window. -> REL.
  - REL: wait until btn==0. This is anti-hold: a held button cannot pre-score. -> LIT.
  - LIT: lights=1<<lane. The timer decrements each cycle.
    - press[lane]=1 with no other press bit set -> HIT.
    - Any other press bit set, including simultaneously with the correct one -> MISS.
    - Timer reaches 0 with no press -> MISS.
    - Press on the same cycle the timer reaches 0 -> the press wins.
  - HIT: lights=0. score+=1, saturating at 2^SCORE_W-1. round_cnt+=1. -> FINISH if the new round_cnt==ROUNDS, else ARM.
  - MISS: same as HIT, but misses+=1 (saturating) and score is unchanged.
  - FINISH: done=1. lights=0. Counters hold their values. start=1 -> CLEAR (new game).
- start is ignored while busy.
- Latency:
  - start sampled -> lights asserted no earlier than cycle 3 (CLEAR, ARM, REL, LIT).
  - Correct press -> score updated 2 cycles after the press edge cycle (LIT->HIT register, then visible).
- Timeout: exactly `window` cycles of LIT with no press produce a MISS.
- Asserting rst mid-game immediately forces all reset values. No partial game is retained.
- round_cnt, score and misses are registered outputs. lights is decoded from state and lane, registered.

Optional Feature:
Macro: REACTION_SPEEDUP_EN.
- Defined: the current window starts at TIMEOUT on CLEAR. Each HIT reduces it by TIMEOUT_STEP, clamped at TIMEOUT_MIN. A MISS leaves it unchanged.
- Undefined: the window is the constant TIMEOUT, and TIMEOUT_STEP/TIMEOUT_MIN are unused.

Decomposition:
- Package reaction_pkg holds:
  - the state enum (IDLE, CLEAR, ARM, REL, LIT, HIT, MISS, FINISH), 3-bit encoding
  - the LFSR tap constant
  - a clog2-based lane-width function
- Sub-module lfsr16: 16-bit Galois LFSR with seed parameter, async reset, and an enable input tied high.
- Timer, edge detect and counters live inside reaction_game_ctrl.

Test Plan:
- Reset mid-LIT: rst pulse while lights!=0 -> lights=0, score=0, round_cnt=0, done=0, and the state is IDLE on the same edge.
- Correct response: N_LANES=4, ROUNDS=3, TIMEOUT=20. Press the lit lane 5 cycles after LIT each round -> score=3, misses=0, done=1, busy=0.
- Timeout and wrong press:
  - Round 1: no press. MISS after exactly 20 LIT cycles.
  - Round 2: wrong lane pressed.
  - Round 3: correct and wrong lanes pressed on the same cycle.
  - Required result: score=0, misses=3.
- Anti-hold: hold btn=4'b1111 through ARM -> stays in REL with lights=0. Release all, then press the lit lane -> HIT counted.
- Saturation and corners:
  - SCORE_W=2, ROUNDS=5, all hits -> score saturates at 3, round_cnt=5.
  - N_LANES=3: over 300 rounds, lights is never 3'b000 or non-one-hot in LIT.
- REACTION_SPEEDUP_EN with TIMEOUT=20, STEP=5, MIN=8: after 3 hits the window is 8 cycles. A press at LIT cycle 9 is a MISS.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction game round controller.
package reaction_pkg;

  // Game phases, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ARM    = 3'd2,
    REL    = 3'd3,
    LIT    = 3'd4,
    HIT    = 3'd5,
    MISS   = 3'd6,
    FINISH = 3'd7
  } state_t;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bits needed to index n lanes; never less than one.
  function automatic int unsigned lane_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_lfsr16.sv
// 16-bit Galois LFSR used as the lane randomiser.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  // Shift right, folding the outgoing bit back through the tap mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Round controller for the button-reaction game: picks a lane, lights it,
// times the response and keeps hit/miss/round counts.
// Optional feature: define REACTION_SPEEDUP_EN to shrink the reaction
// window after every hit (down to TIMEOUT_MIN).
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned N_LANES      = 4,
  parameter int unsigned ROUNDS       = 10,
  parameter int unsigned TIMEOUT      = 50_000_000,
  parameter int unsigned SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned TIMEOUT_STEP = 2_000_000,
  parameter int unsigned TIMEOUT_MIN  = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_LANES-1:0] btn,
  output logic [N_LANES-1:0] lights,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [7:0]         round_cnt,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LW     = lane_width(N_LANES);
  // Timer is sized to hold any window value the game can reach.
  localparam int unsigned WMAX_A = (TIMEOUT > TIMEOUT_MIN) ? TIMEOUT : TIMEOUT_MIN;
  localparam int unsigned WMAX   = (WMAX_A > TIMEOUT_STEP) ? WMAX_A : TIMEOUT_STEP;
  localparam int unsigned TW     = $clog2(WMAX + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [7:0]         ROUNDS_LAST = 8'(ROUNDS);

  state_t             state;
  logic [15:0]        lfsr;
  logic               unused_lfsr_hi;
  logic [N_LANES-1:0] btn_prev;
  logic [N_LANES-1:0] press;
  logic [N_LANES-1:0] lane_hot;
  logic [LW-1:0]      lane_raw;
  logic [LW-1:0]      lane_sel;
  logic [LW-1:0]      lane;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      window;
  logic [7:0]         round_next;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (lfsr)
  );

  // Only the low lane bits of the LFSR pick the lane.
  assign unused_lfsr_hi = ^lfsr[15:LW];

  // Fold out-of-range lane codes back once; the small bias is accepted.
  assign lane_raw = lfsr[LW-1:0];
  assign lane_sel = (32'(lane_raw) >= N_LANES) ? LW'(32'(lane_raw) - N_LANES) : lane_raw;

  // Rising-edge detect on the buttons and the one-hot target.
  assign press      = btn & ~btn_prev;
  assign lane_hot   = N_LANES'(1) << lane;
  assign round_next = round_cnt + 8'd1;

`ifdef REACTION_SPEEDUP_EN
  logic [TW-1:0] window_hit;
  // Next window after a hit, clamped at the floor.
  assign window_hit = (32'(window) >= TIMEOUT_MIN + TIMEOUT_STEP)
                    ? TW'(32'(window) - TIMEOUT_STEP) : TW'(TIMEOUT_MIN);
`else
  assign window = TW'(TIMEOUT);
`endif

  // Game sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lights    <= '0;
      score     <= '0;
      misses    <= '0;
      round_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      btn_prev  <= '0;
      timer     <= '0;
      lane      <= '0;
`ifdef REACTION_SPEEDUP_EN
      window    <= TW'(TIMEOUT);
`endif
    end else begin
      btn_prev <= btn;
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            state <= CLEAR;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        CLEAR: begin
          score     <= '0;
          misses    <= '0;
          round_cnt <= '0;
`ifdef REACTION_SPEEDUP_EN
          window    <= TW'(TIMEOUT);
`endif
          state     <= ARM;
        end
        ARM: begin
          lane  <= lane_sel;
          timer <= window;
          state <= REL;
        end
        REL: begin
          // Wait for every button to be released so a held press cannot score.
          if (btn == '0) begin
            lights <= lane_hot;
            state  <= LIT;
          end
        end
        LIT: begin
          timer <= timer - TW'(1);
          if (press != '0) begin
            lights <= '0;
            state  <= (press == lane_hot) ? HIT : MISS;
          end else if (timer <= TW'(1)) begin
            lights <= '0;
            state  <= MISS;
          end
        end
        HIT, MISS: begin
          if (state == HIT) begin
            if (score != SCORE_MAX) score <= score + SCORE_W'(1);
`ifdef REACTION_SPEEDUP_EN
            window <= window_hit;
`endif
          end else if (misses != SCORE_MAX) begin
            misses <= misses + SCORE_W'(1);
          end
          round_cnt <= round_next;
          if (round_next == ROUNDS_LAST) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: two instances (4 lanes/3 rounds, and
// 3 lanes/5 rounds/2-bit score) checked every cycle against a round-level model.
`timescale 1ns/1ps
module tb_reaction_game_ctrl;

  localparam int T_WIN = 20;
  localparam int STEP  = 5;
  localparam int WMIN  = 8;
  localparam int A_N = 4, A_R = 3, A_SW = 8;
  localparam int B_N = 3, B_R = 5, B_SW = 2;

  localparam int P_IDLE = 0, P_CLR = 1, P_ARM = 2, P_REL = 3,
                 P_LIT = 4, P_HIT = 5, P_MISS = 6, P_FIN = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [3:0] btn_a = '0;
  logic [2:0] btn_b = '0;
  logic [3:0] a_lights;
  logic [2:0] b_lights;
  logic [7:0] a_score, a_misses, a_round, b_round;
  logic [1:0] b_score, b_misses;
  logic a_busy, a_done, b_busy, b_done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reaction_game_ctrl #(.N_LANES(A_N), .ROUNDS(A_R), .TIMEOUT(T_WIN), .SCORE_W(A_SW),
                       .LFSR_SEED(16'hACE1), .TIMEOUT_STEP(STEP), .TIMEOUT_MIN(WMIN)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .btn(btn_a), .lights(a_lights),
    .score(a_score), .misses(a_misses), .round_cnt(a_round), .busy(a_busy), .done(a_done));

  reaction_game_ctrl #(.N_LANES(B_N), .ROUNDS(B_R), .TIMEOUT(T_WIN), .SCORE_W(B_SW),
                       .LFSR_SEED(16'hACE1), .TIMEOUT_STEP(STEP), .TIMEOUT_MIN(WMIN)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .btn(btn_b), .lights(b_lights),
    .score(b_score), .misses(b_misses), .round_cnt(b_round), .busy(b_busy), .done(b_done));

  // ---------------- model ----------------
  typedef struct packed {
    int          ph;
    logic [15:0] lfsr;
    logic [15:0] prev;
    int          lane;
    int          age;
    int          win;
    int          score;
    int          miss;
    int          rounds;
  } mdl_t;

  mdl_t ma, mb;

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int pick_lane(logic [15:0] v, int n);
    int lw = 1;
    int l;
    while ((1 << lw) < n) lw++;
    l = int'(v) & ((1 << lw) - 1);
    if (l >= n) l -= n;
    return l;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t t;
    t = '0;
    t.ph = P_IDLE;
    t.lfsr = 16'hACE1;
    t.win = T_WIN;
    return t;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [15:0] btn, logic start, int n, int rounds, int smax);
    mdl_t t;
    logic [15:0] press, want;
    t = s;
    press = btn & ~s.prev;
    want = 16'(1) << s.lane;
    t.lfsr = lfsr_next(s.lfsr);
    t.prev = btn;
    case (s.ph)
      P_IDLE, P_FIN: if (start) t.ph = P_CLR;
      P_CLR: begin
        t.score = 0; t.miss = 0; t.rounds = 0; t.win = T_WIN; t.ph = P_ARM;
      end
      P_ARM: begin t.lane = pick_lane(s.lfsr, n); t.age = 0; t.ph = P_REL; end
      P_REL: if (btn == 16'h0) t.ph = P_LIT;
      P_LIT: begin
        if (press == want) t.ph = P_HIT;
        else if (press != 16'h0) t.ph = P_MISS;
        else if (s.age + 1 >= s.win) t.ph = P_MISS;
        else t.age = s.age + 1;
      end
      P_HIT, P_MISS: begin
        if (s.ph == P_HIT) begin
          t.score = (s.score < smax) ? s.score + 1 : smax;
`ifdef REACTION_SPEEDUP_EN
          t.win = (s.win - STEP > WMIN) ? s.win - STEP : WMIN;
`endif
        end else begin
          t.miss = (s.miss < smax) ? s.miss + 1 : smax;
        end
        t.rounds = s.rounds + 1;
        t.ph = (t.rounds == rounds) ? P_FIN : P_ARM;
      end
      default: t.ph = P_IDLE;
    endcase
    return t;
  endfunction

  function automatic int m_lights(mdl_t s);
    return (s.ph == P_LIT) ? (1 << s.lane) : 0;
  endfunction
  function automatic int m_busy(mdl_t s);
    return (s.ph != P_IDLE && s.ph != P_FIN) ? 1 : 0;
  endfunction
  function automatic int m_done(mdl_t s);
    return (s.ph == P_FIN) ? 1 : 0;
  endfunction

  // Advance both models on the same edges the DUTs see.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, 16'(btn_a), start_a, A_N, A_R, (1 << A_SW) - 1);
      mb <= mdl_step(mb, 16'(btn_b), start_b, B_N, B_R, (1 << B_SW) - 1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_lights", int'(a_lights), m_lights(ma));
      chk("a_score",  int'(a_score),  ma.score);
      chk("a_misses", int'(a_misses), ma.miss);
      chk("a_round",  int'(a_round),  ma.rounds);
      chk("a_busy",   int'(a_busy),   m_busy(ma));
      chk("a_done",   int'(a_done),   m_done(ma));
      chk("b_lights", int'(b_lights), m_lights(mb));
      chk("b_score",  int'(b_score),  mb.score);
      chk("b_misses", int'(b_misses), mb.miss);
      chk("b_round",  int'(b_round),  mb.rounds);
      chk("b_busy",   int'(b_busy),   m_busy(mb));
      chk("b_done",   int'(b_done),   m_done(mb));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_lit_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_lights != 4'b0) begin ok = 1'b1; break; end
    end
    chk("a_wait_lit", int'(ok), 1);
  endtask

  task automatic wait_lit_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_lights != 3'b0) begin ok = 1'b1; break; end
    end
    chk("b_wait_lit", int'(ok), 1);
  endtask

  task automatic wait_done_a();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (a_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("a_wait_done", int'(ok), 1);
  endtask

  task automatic wait_done_b();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (b_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("b_wait_done", int'(ok), 1);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
  endtask

  // mode 0: lit lane, 2: wrong lane, 3: lit plus wrong; press on LIT cycle d.
  task automatic play_a(input int mode, input int d);
    bit ok;
    logic [3:0] lit, rot;
    wait_lit_a(ok);
    if (!ok) return;
    lit = a_lights;
    rot = {lit[2:0], lit[3]};
    tick(d - 1);
    btn_a = (mode == 0) ? lit : (mode == 2) ? rot : (lit | rot);
    @(negedge clk);
    btn_a = 4'b0;
  endtask

  task automatic play_b(input int d);
    bit ok;
    logic [2:0] lit;
    wait_lit_b(ok);
    if (!ok) return;
    lit = b_lights;
    chk("b_onehot", $countones(b_lights), 1);
    tick(d - 1);
    btn_b = lit;
    @(negedge clk);
    btn_b = 3'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;
    logic [3:0] lit;

    // Reset state and a literal pin of the LFSR step.
    tick(3);
    chk("rst_a_lights", int'(a_lights), 0);
    chk("rst_a_score",  int'(a_score), 0);
    chk("rst_a_busy",   int'(a_busy), 0);
    chk("rst_a_done",   int'(a_done), 0);
    chk("rst_b_round",  int'(b_round), 0);
    chk("lfsr_pin", int'(lfsr_next(16'hACE1)), 32'hE270);
    rst = 1'b0;
    tick(2);

    // Reset in the middle of a lit round.
    pulse_start_a();
    wait_lit_a(ok);
    rst = 1'b1;
    #1;
    chk("mid_rst_lights", int'(a_lights), 0);
    chk("mid_rst_score",  int'(a_score), 0);
    chk("mid_rst_round",  int'(a_round), 0);
    chk("mid_rst_done",   int'(a_done), 0);
    chk("mid_rst_busy",   int'(a_busy), 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Correct responses, press on LIT cycle 5; first round checks score latency.
    pulse_start_a();
    wait_lit_a(ok);
    lit = a_lights;
    tick(4);
    btn_a = lit;
    @(negedge clk);
    btn_a = 4'b0;
    chk("lat_score_hit_cycle", int'(a_score), 0);
    @(negedge clk);
    chk("lat_score_visible", int'(a_score), 1);
    play_a(0, 5);
    play_a(0, 5);
    wait_done_a();
    chk("t2_score",  int'(a_score), 3);
    chk("t2_misses", int'(a_misses), 0);
    chk("t2_round",  int'(a_round), 3);
    chk("t2_done",   int'(a_done), 1);
    chk("t2_busy",   int'(a_busy), 0);

    // Timeout, wrong lane, and correct+wrong together.
    pulse_start_a();
    wait_lit_a(ok);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_lights == 4'b0) break;
      cnt++;
    end
    chk("t3_lit_cycles", cnt, 20);
    play_a(2, 3);
    play_a(3, 2);
    wait_done_a();
    chk("t3_score",  int'(a_score), 0);
    chk("t3_misses", int'(a_misses), 3);
    chk("t3_round",  int'(a_round), 3);

    // Held buttons through ARM keep the lane dark until released.
    btn_a = 4'b1111;
    pulse_start_a();
    tick(10);
    chk("hold_lights", int'(a_lights), 0);
    chk("hold_busy",   int'(a_busy), 1);
    btn_a = 4'b0;
    play_a(0, 2);
    tick(3);
    chk("hold_score", int'(a_score), 1);
    play_a(0, 1);
    play_a(0, 3);
    wait_done_a();
    chk("t4_score", int'(a_score), 3);

`ifdef REACTION_SPEEDUP_EN
    // After three hits the window is 8; a press on LIT cycle 9 is too late.
    pulse_start_b();
    play_b(1);
    play_b(1);
    play_b(1);
    play_b(9);
    play_b(1);
    wait_done_b();
    chk("spd_misses", int'(b_misses), 1);
    chk("spd_score",  int'(b_score), 3);
`endif

    // Saturating 2-bit score and 3-lane selection over 300 rounds.
    for (int g = 0; g < 60; g++) begin
      pulse_start_b();
      for (int r = 0; r < 5; r++) play_b(1);
      wait_done_b();
      chk("sat_score",  int'(b_score), 3);
      chk("sat_round",  int'(b_round), 5);
      chk("sat_misses", int'(b_misses), 0);
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
